vector_execution_scheduler: RTL and testbench
=============================================

Name: vector_execution_scheduler

Overview:
- Parametrised, pipelined successor to the combinational vector execution stage.
- Accepts issued vector operations through a valid/ready handshake and forwards operands from the last writeback result.
- Starts one of NUMBER_FUNCTIONAL_UNITS multi-cycle functional units, each with a fixed per-unit latency, and reserves writeback slots so two results never complete in the same cycle.
- Returns tagged results through a backpressured writeback port. Sits between issue/operand read and the vector register file writeback.

Parameters:
- NUMBER_FUNCTIONAL_UNITS, 4, number of attached functional units (≥1).
- DATA_WIDTH, 128, operand/result width (VLEN slice handled per operation).
- TAG_WIDTH, 5, destination register tag width.
- MAX_LATENCY, 8, largest supported unit latency (≥1).
- UNIT_LATENCY, {4'd4,4'd3,4'd2,4'd1}, packed per-unit latency (entry u = unit u). Each entry is in 1..MAX_LATENCY; elaboration error otherwise.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of all in-flight operations
- issue_valid  input  1  issue request
- issue_ready  output  1  issue accepted when valid&&ready
- issue_unit  input  $clog2(NUMBER_FUNCTIONAL_UNITS)  target unit index
- issue_tag  input  TAG_WIDTH  destination tag
- issue_vs2_tag / issue_vs1_tag  input  TAG_WIDTH each  source tags for bypass compare
- issue_vs2 / issue_vs1  input  DATA_WIDTH each  register-file operands
- unit_start  output  NUMBER_FUNCTIONAL_UNITS  one-hot start pulse
- unit_vs2 / unit_vs1  output  DATA_WIDTH each  operands after bypass (shared by all units)
- unit_stall  output  1  freeze all units this cycle
- unit_result  input  [NUMBER_FUNCTIONAL_UNITS][DATA_WIDTH]  per-unit result bus
- writeback_valid  output  1  result available
- writeback_ready  input  1  consumer accepts result
- writeback_tag  output  TAG_WIDTH  result tag
- writeback_data  output  DATA_WIDTH  result data
- pending_count  output  $clog2(MAX_LATENCY+2)  in-flight ops, including the writeback register

Behaviour:
- Reset (dominates flush): all slots empty, writeback_valid=0, writeback_tag=0, writeback_data=0, pending_count=0, unit_start=0.
- stall = writeback_valid && !writeback_ready; unit_stall = stall. An advancing cycle is any cycle with !stall.
- Slot pipeline: slot[1..MAX_LATENCY], each holding {valid, tag, unit}.
  - On an advancing edge, slot[k] <= slot[k+1] and slot[MAX_LATENCY] <= empty.
  - An accepted issue with L = UNIT_LATENCY[issue_unit] writes slot[L], overriding the shifted value.
  - On a stalled edge, slots hold.
- issue_ready = !reset && !flush && !stall && !(L<MAX_LATENCY && slot[L+1].valid), i.e. no writeback-cycle collision.
  - issue_ready may depend on issue_unit. Issuers must not drop issue_valid before acceptance.
- unit_start[issue_unit] = issue_valid && issue_ready, asserted in the acceptance cycle C.
- Unit contract: unit u presents its result on unit_result[u] during the L-th advancing cycle after C, and holds state while unit_stall=1.
- Writeback register:
  - On an advancing edge, if slot[1].valid: writeback_valid<=1, tag<=slot[1].tag, data<=unit_result[slot[1].unit].
  - Otherwise, if writeback_ready: writeback_valid<=0.
  - Data and tag are stable while valid && !ready.
- Latency: acceptance edge E → writeback_valid high after edge E+L with no stall. Each stall cycle adds one cycle.
- Throughput: one issue per cycle when latencies do not collide. Completion order follows slot order, not issue order; tags identify results.
- Bypass: unit_vs2 = (writeback_valid && issue_vs2_tag==writeback_tag) ? writeback_data : issue_vs2. unit_vs1 is computed the same way. Combinational; no other forwarding.
- pending_count: +1 on accept, −1 on writeback handshake, unchanged when both occur in the same cycle.
- flush: clears all slots, writeback_valid and pending_count on that edge. issue_ready=0 during flush. Units must also be flushed by their owner.
- Reset or flush with a result held under backpressure discards that result.

Test Plan:
- Single op: unit 3 (L=1), tag 5, vs1=0x11, ready=1 → unit_start=4'b1000, writeback_valid high one cycle later with tag 5 and unit_result[3] data; pending_count 1→0.
- Collision: issue unit 0 (L=4) at cycle 0, then unit 1 (L=3) at cycle 1 (slot[4] occupied) → issue_ready=0 at cycle 1. Unit 1 accepted at cycle 2; writebacks at cycles 4 and 5.
- Out-of-order completion: unit 0 (L=4) tag 1, next cycle unit 3 (L=1) tag 2 → tag 2 written back before tag 1; both delivered exactly once.
- Backpressure: writeback_ready=0 for 3 cycles with two ops in flight → data/tag stable, unit_stall=1, issue_ready=0. Release → results in original slot order, no loss or duplication.
- Bypass: writeback_valid with tag 7, data 0xAB; issue vs2_tag=7, vs1_tag=3 → unit_vs2=0xAB, unit_vs1=issue_vs1.
- Flush/reset: flush with 3 in flight and a held result → next cycle writeback_valid=0, pending_count=0, issue_ready=1. Repeat with reset → same, with writeback_data=0.

Source files
------------

// File: rtl/vector_execution_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vector_execution_scheduler
// Description : Pipelined vector execution scheduler. Accepts issued ops over
//               valid/ready, bypasses operands from the writeback register,
//               starts multi-cycle functional units and reserves writeback
//               slots so no two results complete in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_execution_scheduler #(
  parameter int NUMBER_FUNCTIONAL_UNITS = 4,
  parameter int DATA_WIDTH              = 128,
  parameter int TAG_WIDTH               = 5,
  parameter int MAX_LATENCY             = 8,
  // Entry u (index u of the ascending packed range) is the latency of unit u.
  parameter logic [0:NUMBER_FUNCTIONAL_UNITS-1][3:0] UNIT_LATENCY = {4'd4, 4'd3, 4'd2, 4'd1},
  localparam int UW = (NUMBER_FUNCTIONAL_UNITS > 1) ? $clog2(NUMBER_FUNCTIONAL_UNITS) : 1,
  localparam int PW = $clog2(MAX_LATENCY + 2)
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic                                            flush,
  input  logic                                            issue_valid,
  output logic                                            issue_ready,
  input  logic [UW-1:0]                                   issue_unit,
  input  logic [TAG_WIDTH-1:0]                            issue_tag,
  input  logic [TAG_WIDTH-1:0]                            issue_vs2_tag,
  input  logic [TAG_WIDTH-1:0]                            issue_vs1_tag,
  input  logic [DATA_WIDTH-1:0]                           issue_vs2,
  input  logic [DATA_WIDTH-1:0]                           issue_vs1,
  output logic [NUMBER_FUNCTIONAL_UNITS-1:0]              unit_start,
  output logic [DATA_WIDTH-1:0]                           unit_vs2,
  output logic [DATA_WIDTH-1:0]                           unit_vs1,
  output logic                                            unit_stall,
  input  logic [NUMBER_FUNCTIONAL_UNITS-1:0][DATA_WIDTH-1:0] unit_result,
  output logic                                            writeback_valid,
  input  logic                                            writeback_ready,
  output logic [TAG_WIDTH-1:0]                            writeback_tag,
  output logic [DATA_WIDTH-1:0]                           writeback_data,
  output logic [PW-1:0]                                   pending_count
);

  localparam logic [PW-1:0] c_one = PW'(1);

  // Reject unit latencies the slot pipeline cannot represent.
  for (genvar u = 0; u < NUMBER_FUNCTIONAL_UNITS; u++) begin : g_lat_check
    if (UNIT_LATENCY[u] == 4'd0 || int'(UNIT_LATENCY[u]) > MAX_LATENCY) begin : g_bad_latency
      $error("UNIT_LATENCY entry out of range 1..MAX_LATENCY");
    end
  end

  // Slot k holds the op whose result is written back k advancing edges from now.
  logic [MAX_LATENCY:1]                r_slot_valid;
  logic [MAX_LATENCY:1][TAG_WIDTH-1:0] r_slot_tag;
  logic [MAX_LATENCY:1][UW-1:0]        r_slot_unit;

  logic                  r_wb_valid;
  logic [TAG_WIDTH-1:0]  r_wb_tag;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic [PW-1:0]         r_pending;

  logic       w_stall;
  logic [3:0] w_lat;
  logic       w_collide;
  logic       w_accept;
  logic       w_wb_fire;

  assign w_stall   = r_wb_valid && !writeback_ready;
  assign w_wb_fire = r_wb_valid && writeback_ready;

  // Look up the target unit latency and detect a writeback-slot collision.
  always_comb begin
    w_lat     = 4'd1;
    w_collide = 1'b0;
    for (int u = 0; u < NUMBER_FUNCTIONAL_UNITS; u++) begin
      if (int'(issue_unit) == u) w_lat = UNIT_LATENCY[u];
    end
    // slot[L+1] would shift into slot[L] on the same edge the new op lands there.
    for (int k = 2; k <= MAX_LATENCY; k++) begin
      if (int'(w_lat) + 1 == k && r_slot_valid[k]) w_collide = 1'b1;
    end
  end

  assign issue_ready = !reset && !flush && !w_stall && !w_collide;
  assign w_accept    = issue_valid && issue_ready;

  // One-hot start pulse to the selected unit in the acceptance cycle.
  always_comb begin
    unit_start = '0;
    for (int u = 0; u < NUMBER_FUNCTIONAL_UNITS; u++) begin
      if (int'(issue_unit) == u) unit_start[u] = w_accept;
    end
  end

  // Forward the held writeback result to matching source operands.
  always_comb begin
    unit_vs2 = (r_wb_valid && issue_vs2_tag == r_wb_tag) ? r_wb_data : issue_vs2;
    unit_vs1 = (r_wb_valid && issue_vs1_tag == r_wb_tag) ? r_wb_data : issue_vs1;
  end

  // Slot pipeline: shift toward slot 1 on advancing edges, insert accepted op at slot L.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_slot_valid <= '0;
      r_slot_tag   <= '0;
      r_slot_unit  <= '0;
    end else if (!w_stall) begin
      for (int k = 1; k < MAX_LATENCY; k++) begin
        r_slot_valid[k] <= r_slot_valid[k+1];
        r_slot_tag[k]   <= r_slot_tag[k+1];
        r_slot_unit[k]  <= r_slot_unit[k+1];
      end
      r_slot_valid[MAX_LATENCY] <= 1'b0;
      if (w_accept) begin
        for (int k = 1; k <= MAX_LATENCY; k++) begin
          if (int'(w_lat) == k) begin
            r_slot_valid[k] <= 1'b1;
            r_slot_tag[k]   <= issue_tag;
            r_slot_unit[k]  <= issue_unit;
          end
        end
      end
    end
  end

  // Writeback register: capture the unit result when slot 1 matures, hold under backpressure.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_tag   <= '0;
      r_wb_data  <= '0;
    end else if (flush) begin
      r_wb_valid <= 1'b0;
    end else if (!w_stall) begin
      if (r_slot_valid[1]) begin
        r_wb_valid <= 1'b1;
        r_wb_tag   <= r_slot_tag[1];
        r_wb_data  <= unit_result[r_slot_unit[1]];
      end else if (writeback_ready) begin
        r_wb_valid <= 1'b0;
      end
    end
  end

  // Count ops between acceptance and writeback handshake.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_pending <= '0;
    end else begin
      case ({w_accept, w_wb_fire})
        2'b10:   r_pending <= r_pending + c_one;
        2'b01:   r_pending <= r_pending - c_one;
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign unit_stall      = w_stall;
  assign writeback_valid = r_wb_valid;
  assign writeback_tag   = r_wb_tag;
  assign writeback_data  = r_wb_data;
  assign pending_count   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_vector_execution_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_execution_scheduler
// Description : Directed self-checking bench for vector_execution_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_execution_scheduler;

  logic              clock = 1'b0;
  logic              reset, flush;
  logic              issue_valid, issue_ready;
  logic [1:0]        issue_unit;
  logic [4:0]        issue_tag, issue_vs2_tag, issue_vs1_tag;
  logic [127:0]      issue_vs2, issue_vs1;
  logic [3:0]        unit_start;
  logic [127:0]      unit_vs2, unit_vs1;
  logic              unit_stall;
  logic [3:0][127:0] unit_result;
  logic              writeback_valid, writeback_ready;
  logic [4:0]        writeback_tag;
  logic [127:0]      writeback_data;
  logic [3:0]        pending_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] D0 = 128'hD0;
  localparam logic [127:0] D1 = 128'hD1;
  localparam logic [127:0] D2 = 128'hD2;
  localparam logic [127:0] D3 = 128'hD3;

  vector_execution_scheduler dut (
    .clock(clock), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_unit(issue_unit),
    .issue_tag(issue_tag), .issue_vs2_tag(issue_vs2_tag), .issue_vs1_tag(issue_vs1_tag),
    .issue_vs2(issue_vs2), .issue_vs1(issue_vs1),
    .unit_start(unit_start), .unit_vs2(unit_vs2), .unit_vs1(unit_vs1),
    .unit_stall(unit_stall), .unit_result(unit_result),
    .writeback_valid(writeback_valid), .writeback_ready(writeback_ready),
    .writeback_tag(writeback_tag), .writeback_data(writeback_data),
    .pending_count(pending_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic issue(input logic [1:0] u, input logic [4:0] t);
    issue_valid = 1'b1;
    issue_unit  = u;
    issue_tag   = t;
  endtask

  // Three ops in flight with unit 2 (tag 7, data 0xAB) held in the writeback register.
  task automatic load_three();
    writeback_ready = 1'b1;
    issue(2'd0, 5'd12); #1 chk("setup_rdy0", 128'(issue_ready), 128'd1); tick();
    issue(2'd2, 5'd7);  #1 chk("setup_rdy1", 128'(issue_ready), 128'd1); tick();
    issue(2'd1, 5'd13); #1 chk("setup_rdy2", 128'(issue_ready), 128'd1); tick();
    issue_valid = 1'b0; tick();
    chk("setup_wb_tag",  128'(writeback_tag), 128'd7);
    chk("setup_wb_data", writeback_data, 128'hAB);
    chk("setup_pending", 128'(pending_count), 128'd3);
    writeback_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_unit = '0; issue_tag = '0;
    issue_vs2_tag = 5'd9; issue_vs1_tag = 5'd10; issue_vs2 = 128'h22; issue_vs1 = 128'h11;
    writeback_ready = 1'b1;
    unit_result[0] = D0; unit_result[1] = D1; unit_result[2] = D2; unit_result[3] = D3;

    // Reset state
    tick(); tick(); #1;
    chk("rst_wb_valid", 128'(writeback_valid), 128'd0);
    chk("rst_wb_tag",   128'(writeback_tag),   128'd0);
    chk("rst_wb_data",  writeback_data,        128'd0);
    chk("rst_pending",  128'(pending_count),   128'd0);
    chk("rst_start",    128'(unit_start),      128'd0);
    chk("rst_ready",    128'(issue_ready),     128'd0);
    reset = 1'b0; tick();

    // Single op on unit 3 (L=1)
    issue(2'd3, 5'd5); #1;
    chk("s_ready", 128'(issue_ready), 128'd1);
    chk("s_start", 128'(unit_start), 128'b1000);
    chk("s_vs1",   unit_vs1, 128'h11);
    chk("s_vs2",   unit_vs2, 128'h22);
    tick(); issue_valid = 1'b0; #1;
    chk("s_pend1",  128'(pending_count), 128'd1);
    chk("s_wbv0",   128'(writeback_valid), 128'd0);
    tick();
    chk("s_wbv1",   128'(writeback_valid), 128'd1);
    chk("s_tag",    128'(writeback_tag), 128'd5);
    chk("s_data",   writeback_data, D3);
    tick();
    chk("s_wbv_end", 128'(writeback_valid), 128'd0);
    chk("s_pend0",   128'(pending_count), 128'd0);

    // Collision: unit 0 (L=4) then unit 1 (L=3)
    issue(2'd0, 5'd1); #1;
    chk("c_ready0", 128'(issue_ready), 128'd1);
    chk("c_start0", 128'(unit_start), 128'b0001);
    tick();
    issue(2'd1, 5'd2); #1;
    chk("c_ready1", 128'(issue_ready), 128'd0);
    chk("c_start1", 128'(unit_start), 128'b0000);
    tick(); #1;
    chk("c_ready2", 128'(issue_ready), 128'd1);
    chk("c_start2", 128'(unit_start), 128'b0010);
    tick(); issue_valid = 1'b0;
    tick();
    chk("c_wbv3", 128'(writeback_valid), 128'd0);
    tick();
    chk("c_tag4",  128'(writeback_tag), 128'd1);
    chk("c_data4", writeback_data, D0);
    chk("c_pend4", 128'(pending_count), 128'd2);
    tick();
    chk("c_tag5",  128'(writeback_tag), 128'd2);
    chk("c_data5", writeback_data, D1);
    chk("c_pend5", 128'(pending_count), 128'd1);
    tick();
    chk("c_wbv6",  128'(writeback_valid), 128'd0);
    chk("c_pend6", 128'(pending_count), 128'd0);

    // Out-of-order completion
    issue(2'd0, 5'd1); tick();
    issue(2'd3, 5'd2); #1;
    chk("o_ready", 128'(issue_ready), 128'd1);
    tick(); issue_valid = 1'b0;
    tick();
    chk("o_tag_first",  128'(writeback_tag), 128'd2);
    chk("o_data_first", writeback_data, D3);
    tick();
    chk("o_gap", 128'(writeback_valid), 128'd0);
    tick();
    chk("o_tag_second",  128'(writeback_tag), 128'd1);
    chk("o_data_second", writeback_data, D0);
    tick();
    chk("o_wbv_end", 128'(writeback_valid), 128'd0);
    chk("o_pend_end", 128'(pending_count), 128'd0);

    // Backpressure with two ops in flight
    issue(2'd3, 5'd4); tick();
    issue(2'd2, 5'd3); #1;
    chk("b_ready_issue", 128'(issue_ready), 128'd1);
    tick();
    issue(2'd1, 5'd9); writeback_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      #1;
      chk("b_wbv",   128'(writeback_valid), 128'd1);
      chk("b_tag",   128'(writeback_tag), 128'd4);
      chk("b_data",  writeback_data, D3);
      chk("b_stall", 128'(unit_stall), 128'd1);
      chk("b_ready", 128'(issue_ready), 128'd0);
      chk("b_start", 128'(unit_start), 128'd0);
      chk("b_pend",  128'(pending_count), 128'd2);
    end
    issue_valid = 1'b0; writeback_ready = 1'b1; #1;
    chk("b_release_stall", 128'(unit_stall), 128'd0);
    tick();
    chk("b_gap",   128'(writeback_valid), 128'd0);
    chk("b_pend1", 128'(pending_count), 128'd1);
    tick();
    chk("b_tag2",  128'(writeback_tag), 128'd3);
    chk("b_data2", writeback_data, D2);
    tick();
    chk("b_wbv_end",  128'(writeback_valid), 128'd0);
    chk("b_pend_end", 128'(pending_count), 128'd0);

    // Bypass from held result, then flush
    unit_result[2] = 128'hAB;
    load_three();
    issue_vs2_tag = 5'd7; issue_vs1_tag = 5'd3; issue_vs2 = 128'h55; issue_vs1 = 128'h66; #1;
    chk("byp_vs2", unit_vs2, 128'hAB);
    chk("byp_vs1", unit_vs1, 128'h66);
    tick();
    chk("byp_hold_tag",  128'(writeback_tag), 128'd7);
    chk("byp_hold_data", writeback_data, 128'hAB);
    flush = 1'b1; issue(2'd3, 5'd20); #1;
    chk("f_ready_during", 128'(issue_ready), 128'd0);
    chk("f_start_during", 128'(unit_start), 128'd0);
    tick();
    flush = 1'b0; issue_valid = 1'b0; writeback_ready = 1'b1; #1;
    chk("f_wbv",   128'(writeback_valid), 128'd0);
    chk("f_pend",  128'(pending_count), 128'd0);
    chk("f_ready", 128'(issue_ready), 128'd1);
    repeat (6) tick();
    chk("f_wbv_late", 128'(writeback_valid), 128'd0);

    // Same with reset
    load_three();
    reset = 1'b1; #1;
    chk("r_ready_during", 128'(issue_ready), 128'd0);
    tick();
    reset = 1'b0; writeback_ready = 1'b1; #1;
    chk("r_wbv",   128'(writeback_valid), 128'd0);
    chk("r_tag",   128'(writeback_tag), 128'd0);
    chk("r_data",  writeback_data, 128'd0);
    chk("r_pend",  128'(pending_count), 128'd0);
    chk("r_ready", 128'(issue_ready), 128'd1);
    repeat (6) tick();
    chk("r_wbv_late", 128'(writeback_valid), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
